// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
// Stand-alone UART receiver. The serial line is synchronized, sampled three
// times around the middle of every bit (offsets h-1, h, h+1 with h = P/2) and
// majority-voted. Optional even/odd parity and the stop bit are checked. A good
// frame updates p_data with a one-cycle data_valid strobe. A bad frame raises a
// one-cycle parity_error or stop_error strobe and leaves p_data untouched.
module uart_rx_oversample #(
  parameter int DWIDTH   = 8,
  parameter int PWIDTH   = 6,
  parameter int PRESCALE = 8
) (
  input  logic              clk_rx,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              parity_en,
  input  logic              parity_type,
  input  logic [PWIDTH-1:0] prescale,
  output logic [DWIDTH-1:0] p_data,
  output logic              data_valid,
  output logic              parity_error,
  output logic              stop_error
);

  localparam int                BW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [PWIDTH-1:0] P_MIN    = PWIDTH'(4);
  localparam logic [PWIDTH-1:0] P_RST    = (PRESCALE < 4) ? P_MIN : PWIDTH'(PRESCALE);
  localparam logic [BW-1:0]     LAST_BIT = BW'(DWIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t state_q, state_d;

  // Synchronized line
  logic rx_meta;
  logic rx_s;

  // Frame configuration, frozen at the start edge
  logic [PWIDTH-1:0] p_q;
  logic              par_en_q;
  logic              par_type_q;

  // Bit timing and sampling
  logic [PWIDTH-1:0] cnt_q, cnt_d;
  logic [PWIDTH-1:0] half;
  logic [PWIDTH-1:0] p_in_eff;
  logic [BW-1:0]     bit_q;
  logic [1:0]        samp_q;
  logic              at_s0, at_s1, at_dec, at_end;
  logic              maj;

  // Received data and parity result
  logic [DWIDTH-1:0] shreg_q;
  logic              par_err_q;

  // FSM control strobes
  logic start_frame;
  logic shift_en;
  logic bit_inc;
  logic par_chk;
  logic stop_dec;

  // Two-flop synchronizer; both flops reset to the idle-high line level so
  // reset can never be mistaken for a start edge.
  always_ff @(posedge clk_rx) begin
    // NOTE: clocked blocks use non-blocking assignments only, so rx_s takes the
    // pre-edge value of rx_meta and the two flops really form a two-stage chain.
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Position decode within the current bit and the 3-sample majority vote.
  assign p_in_eff = (prescale < P_MIN) ? P_MIN : prescale;
  assign half     = p_q >> 1;
  assign at_s0    = (cnt_q == (half - PWIDTH'(1)));
  assign at_s1    = (cnt_q == half);
  assign at_dec   = (cnt_q == (half + PWIDTH'(1)));
  assign at_end   = (cnt_q == (p_q - PWIDTH'(1)));
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // FSM state register.
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    bit_inc     = 1'b0;
    par_chk     = 1'b0;
    stop_dec    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          start_frame = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        // A start bit that votes high was only a glitch.
        if (at_dec && maj) begin
          state_d = ST_IDLE;
        end else if (at_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        shift_en = at_dec;
        bit_inc  = at_end;
        if (at_end && (bit_q == LAST_BIT)) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        par_chk = at_dec;
        if (at_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at the decision point so an immediate next start is caught.
        if (at_dec) begin
          stop_dec = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Edge counter: the IDLE cycle that sees the start edge is offset 0 of the
  // start bit, so the counter leaves IDLE already at 1.
  always_comb begin
    cnt_d = cnt_q + PWIDTH'(1);
    if (state_q == ST_IDLE) begin
      cnt_d = start_frame ? PWIDTH'(1) : '0;
    end else if ((state_d == ST_IDLE) || at_end) begin
      cnt_d = '0;
    end
  end

  // Frame datapath: configuration latch, counters, samples, shift register
  // and stored parity result.
  always_ff @(posedge clk_rx) begin
    // NOTE: the datapath registers are reset as well, so no frame state can
    // leak across a reset that lands mid-frame.
    if (rst) begin
      p_q        <= P_RST;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      samp_q     <= 2'b11;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (start_frame) begin
        p_q        <= p_in_eff;
        par_en_q   <= parity_en;
        par_type_q <= parity_type;
        bit_q      <= '0;
        par_err_q  <= 1'b0;
      end
      if (state_q != ST_IDLE) begin
        if (at_s0) samp_q[0] <= rx_s;
        if (at_s1) samp_q[1] <= rx_s;
      end
      if (bit_inc) begin
        bit_q <= bit_q + BW'(1);
      end
      if (shift_en) begin
        shreg_q <= {maj, shreg_q[DWIDTH-1:1]};
      end
      if (par_chk) begin
        par_err_q <= maj ^ (^shreg_q) ^ par_type_q;
      end
    end
  end

  // Frame outcome, registered: strobes last one cycle, p_data only moves on a
  // good frame and parity failure wins over stop failure.
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      p_data       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      if (stop_dec) begin
        if (par_err_q) begin
          parity_error <= 1'b1;
        end else if (!maj) begin
          stop_error <= 1'b1;
        end else begin
          p_data     <= shreg_q;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample
// Directed and randomized frames on rx_in. A reference model reconstructs the
// synchronized line from the recorded rx_in/rst history, votes every bit from
// the three samples around its centre and predicts the strobes and p_data for
// every cycle. A few literal latencies and data values pin the model.
module tb_uart_rx_oversample;

  localparam int DW   = 8;
  localparam int PW   = 6;
  localparam int MAXC = 100000;
  localparam int EVN  = 1024;

  logic          clk_rx      = 1'b0;
  logic          rst         = 1'b1;
  logic          rx_in       = 1'b1;
  logic          parity_en   = 1'b0;
  logic          parity_type = 1'b0;
  logic [PW-1:0] prescale    = PW'(8);
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          parity_error;
  logic          stop_error;

  uart_rx_oversample #(.DWIDTH(DW), .PWIDTH(PW), .PRESCALE(8)) dut (
    .clk_rx      (clk_rx),
    .rst         (rst),
    .rx_in       (rx_in),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .prescale    (prescale),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .parity_error(parity_error),
    .stop_error  (stop_error)
  );

  always #5 clk_rx = ~clk_rx;

  int cyc = 0;
  always @(posedge clk_rx) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line history and model state
  bit rxin_h [MAXC];
  bit rst_h  [MAXC];
  bit rxs_h  [MAXC];

  bit            m_ok   = 1'b0;
  bit            m_busy = 1'b0;
  int            m_t0, m_p;
  bit            m_pe, m_pt;
  logic          e_dv = 1'b0, e_pe = 1'b0, e_se = 1'b0;
  logic [DW-1:0] e_pd = '0;

  // Strobe event logs (kind = {stop_error, parity_error, data_valid})
  int            dut_ev_cnt = 0;
  logic [2:0]    dut_ev_kind [EVN];
  int            dut_ev_cyc  [EVN];
  logic [DW-1:0] dut_ev_pd   [EVN];
  int            mdl_ev_cnt = 0;
  logic [2:0]    mdl_ev_kind [EVN];
  int            mdl_ev_cyc  [EVN];

  function automatic bit maj3(input int base, input int h);
    int s;
    s = int'(rxs_h[base+h-1]) + int'(rxs_h[base+h]) + int'(rxs_h[base+h+1]);
    return s >= 2;
  endfunction

  // Record this cycle's inputs and predict the outputs of the next cycle.
  task automatic model_step(input int n);
    int            h, s;
    logic [DW-1:0] d;
    bit            pb, sb;
    rxin_h[n] = rx_in;
    rst_h[n]  = rst;
    if (n < 2)                        rxs_h[n] = 1'b1;
    else if (rst_h[n-1] || rst_h[n-2]) rxs_h[n] = 1'b1;
    else                              rxs_h[n] = rxin_h[n-2];
    e_dv = 1'b0;
    e_pe = 1'b0;
    e_se = 1'b0;
    if (rst === 1'b1) begin
      m_ok   = 1'b1;
      m_busy = 1'b0;
      e_pd   = '0;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (rxs_h[n] == 1'b0) begin
          m_busy = 1'b1;
          m_t0   = n;
          m_p    = (int'(prescale) < 4) ? 4 : int'(prescale);
          m_pe   = parity_en;
          m_pt   = parity_type;
        end
      end else begin
        h = m_p / 2;
        s = 1 + DW + int'(m_pe);
        if (n == m_t0 + h + 1 && maj3(m_t0, h)) begin
          m_busy = 1'b0;
        end else if (n == m_t0 + s * m_p + h + 1) begin
          for (int i = 0; i < DW; i++) d[i] = maj3(m_t0 + (i + 1) * m_p, h);
          pb = maj3(m_t0 + (DW + 1) * m_p, h);
          sb = maj3(m_t0 + s * m_p, h);
          if (m_pe && (pb != ((^d) ^ m_pt))) e_pe = 1'b1;
          else if (!sb)                       e_se = 1'b1;
          else begin
            e_dv = 1'b1;
            e_pd = d;
          end
          m_busy = 1'b0;
          if (mdl_ev_cnt < EVN) begin
            mdl_ev_kind[mdl_ev_cnt] = {e_se, e_pe, e_dv};
            mdl_ev_cyc[mdl_ev_cnt]  = n + 1;
          end
          mdl_ev_cnt++;
        end
      end
    end
  endtask

  // Compare process: outputs are checked mid-cycle against the prediction.
  always @(negedge clk_rx) begin
    if (m_ok) begin
      check("data_valid", data_valid, e_dv);
      check("parity_error", parity_error, e_pe);
      check("stop_error", stop_error, e_se);
      check("p_data", p_data, e_pd);
      if (data_valid === 1'b1 || parity_error === 1'b1 || stop_error === 1'b1) begin
        if (dut_ev_cnt < EVN) begin
          dut_ev_kind[dut_ev_cnt] = {stop_error, parity_error, data_valid};
          dut_ev_cyc[dut_ev_cnt]  = cyc;
          dut_ev_pd[dut_ev_cnt]   = p_data;
        end
        dut_ev_cnt++;
      end
    end
    if (cyc < MAXC) model_step(cyc);
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic drive(input bit b, input int p);
    rx_in = b;
    repeat (p) tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int pin, input bit pe, input bit pt,
                            input bit bad_par, input bit stop_b, input bit scramble,
                            output int start);
    int p;
    p           = (pin < 4) ? 4 : pin;
    prescale    = PW'(pin);
    parity_en   = pe;
    parity_type = pt;
    start       = cyc;
    drive(1'b0, p);
    // Configuration inputs may wander once the frame has latched them.
    if (scramble) begin
      prescale    = PW'($urandom);
      parity_en   = 1'($urandom);
      parity_type = 1'($urandom);
    end
    for (int i = 0; i < DW; i++) drive(d[i], p);
    if (pe) drive((^d) ^ pt ^ bad_par, p);
    drive(stop_b, p);
  endtask

  task automatic check_frame(input string name, input int idx, input int start,
                             input logic [2:0] kind, input int lat, input logic [DW-1:0] pd);
    int budget;
    budget = 400;
    while (dut_ev_cnt <= idx && budget > 0) begin
      tick();
      budget--;
    end
    if (dut_ev_cnt <= idx) begin
      check({name, "_timeout"}, dut_ev_cnt, idx + 1);
      return;
    end
    check({name, "_kind"}, dut_ev_kind[idx], kind);
    check({name, "_latency"}, dut_ev_cyc[idx] - start, lat);
    check({name, "_p_data"}, dut_ev_pd[idx], pd);
    check({name, "_model_kind"}, mdl_ev_kind[idx], kind);
    check({name, "_model_latency"}, mdl_ev_cyc[idx] - start, lat);
  endtask

  initial begin
    int st, st2, c0;
    repeat (4) tick();
    check("reset_p_data", p_data, 0);
    check("reset_strobes", {stop_error, parity_error, data_valid}, 0);
    rst = 1'b0;
    drive(1'b1, 10);

    // 0xAA, no parity, P = 8: strobe 2 sync cycles + 9*8 + 4 + 2 after the edge
    c0 = dut_ev_cnt;
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st);
    check_frame("aa_noparity", c0, st, 3'b001, 80, 8'hAA);
    drive(1'b1, 20);

    // Even parity good, then odd parity with a wrong parity bit
    c0 = dut_ev_cnt;
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, st);
    check_frame("55_even", c0, st, 3'b001, 88, 8'h55);
    drive(1'b1, 20);
    c0 = dut_ev_cnt;
    send_frame(8'hAA, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, st);
    check_frame("aa_odd_bad", c0, st, 3'b010, 88, 8'h55);
    drive(1'b1, 20);

    // Stop bit low
    c0 = dut_ev_cnt;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st);
    check_frame("3c_stop0", c0, st, 3'b100, 80, 8'h55);
    drive(1'b1, 20);

    // Start glitch, then a good frame
    c0 = dut_ev_cnt;
    drive(1'b0, 2);
    drive(1'b1, 20);
    check("glitch_no_strobe", dut_ev_cnt, c0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st);
    check_frame("81_after_glitch", c0, st, 3'b001, 80, 8'h81);
    drive(1'b1, 20);

    // prescale below the floor runs at P = 4: 2 + 9*4 + 2 + 2
    c0 = dut_ev_cnt;
    send_frame(8'hC3, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st);
    check_frame("c3_p4", c0, st, 3'b001, 42, 8'hC3);
    drive(1'b1, 20);

    // Back-to-back at P = 16
    c0 = dut_ev_cnt;
    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st);
    send_frame(8'h34, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st2);
    check_frame("b2b_12", c0, st, 3'b001, 156, 8'h12);
    check_frame("b2b_34", c0 + 1, st2, 3'b001, 156, 8'h34);
    drive(1'b1, 40);

    // Line stuck low: first frame fails on its stop bit, receiver keeps going
    c0 = dut_ev_cnt;
    prescale = PW'(8);
    st = cyc;
    drive(1'b0, 100);
    check_frame("stuck_low", c0, st, 3'b100, 80, 8'h34);
    drive(1'b1, 120);

    // Reset during data bit 4 of 0xF0, then 0x0F
    prescale  = PW'(8);
    parity_en = 1'b0;
    c0 = dut_ev_cnt;
    drive(1'b0, 8);
    for (int i = 0; i < 4; i++) drive(1'b0, 8);
    drive(1'b1, 3);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    drive(1'b1, 20);
    check("reset_abort_no_strobe", dut_ev_cnt, c0);
    check("reset_abort_p_data", p_data, 0);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st);
    check_frame("0f_after_reset", c0, st, 3'b001, 80, 8'h0F);
    drive(1'b1, 20);

    // Randomized frames: prescale, parity, errors, gaps and glitches
    for (int k = 0; k < 40; k++) begin
      int            pin;
      bit            pe, pt, badp, stopb;
      logic [DW-1:0] d;
      pin   = $urandom_range(0, 20);
      pe    = 1'($urandom);
      pt    = 1'($urandom);
      badp  = ($urandom_range(0, 5) == 0);
      stopb = ($urandom_range(0, 5) != 0);
      d     = DW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b0, $urandom_range(1, 2));
        drive(1'b1, 30);
      end
      send_frame(d, pin, pe, pt, badp, stopb, 1'b1, st);
      drive(1'b1, $urandom_range(0, 6));
    end
    drive(1'b1, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
